regfile_seq_ctrl: RTL

- Program sequencer for the REGFILE_CR register file.
- On START it walks the instruction half of the register file and drives `SEQ_INS`.
- It decodes each returned `INS_OUT` and drives `SEQ_DATC` to present data rows (`MAT_IN`) to the PE array through a valid/ready handshake.
- It also launches and waits on compute passes, and stops on HALT.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_seq_ctrl_if.sv | 36 +++
 rtl/regfile_seq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the REGFILE_CR program sequencer.
// Holds the opcode and state enums, the opcode field position and a row-field helper.
package regfile_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_LDB  = 4'h2,
        OP_EXEC = 4'h3,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_EXEC,
        S_DONE,
        S_ERR
    } seq_state_e;

    // The row index sits in the low bits. n is a power of two, so masking
    // with n-1 keeps just the row bits. The caller truncates to its row width.
    function automatic logic [31:0] row_field(input logic [31:0] ins,
                                              input int unsigned n);
        return ins & (n - 1);
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// Bundle between the sequencer and REGFILE_CR / PE array.
// master: sequencer side (drives SEQ_*, MAT_VALID/SEL, EXEC_START, BUSY, DONE, ERR).
interface regfile_seq_ctrl_if #(
    parameter int N    = 16,
    parameter int REGN = 512
);
    localparam int PC_W  = $clog2(REGN / 2);
    localparam int ROW_W = $clog2(N);

    logic             START;
    logic             ABORT;
    logic [PC_W-1:0]  SEQ_INS;
    logic [31:0]      INS_OUT;
    logic [ROW_W-1:0] SEQ_DATC;
    logic             MAT_VALID;
    logic             MAT_SEL;
    logic             MAT_READY;
    logic             EXEC_START;
    logic             EXEC_DONE;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        input  START, ABORT, INS_OUT, MAT_READY, EXEC_DONE,
        output SEQ_INS, SEQ_DATC, MAT_VALID, MAT_SEL,
        output EXEC_START, BUSY, DONE, ERR
    );

    modport slave (
        output START, ABORT, INS_OUT, MAT_READY, EXEC_DONE,
        input  SEQ_INS, SEQ_DATC, MAT_VALID, MAT_SEL,
        input  EXEC_START, BUSY, DONE, ERR
    );

endinterface

// File: rtl/regfile_seq_ctrl.sv
// Program sequencer: walks the instruction half of REGFILE_CR, issues A/B rows,
// launches compute passes, stops on HALT. Ports: CLK, RSTN (async, active high), bus.
module regfile_seq_ctrl
    import regfile_pkg::*;
#(
    parameter int N       = 16,
    parameter int REGN    = 512,
    parameter int B_START = 256
) (
    input  logic               CLK,
    input  logic               RSTN,
    regfile_seq_ctrl_if.master bus
);

    localparam int PC_W  = $clog2(REGN / 2);
    localparam int ROW_W = $clog2(N);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(REGN / 2 - 1);

    if (B_START < REGN / 2 || B_START >= REGN || (N & (N - 1)) != 0) begin : g_bad_cfg
        $error("N must be a power of 2 and B_START must lie in the data half");
    end

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [ROW_W-1:0] datc_q, datc_d;
    logic             sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             xstart_q, xstart_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0]       opc;
    logic [ROW_W-1:0] row;
    seq_state_e       adv_state;
    logic [PC_W-1:0]  adv_pc;

    assign opc = bus.INS_OUT[OP_MSB:OP_LSB];
    assign row = ROW_W'(row_field(bus.INS_OUT, N));

    // Completing the last instruction slot is an error; the PC never wraps.
    assign adv_state = (pc_q == PC_LAST) ? S_ERR : S_FETCH;
    assign adv_pc    = (pc_q == PC_LAST) ? pc_q : pc_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        datc_d   = datc_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        xstart_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (opc)
                    OP_NOP: begin
                        state_d = adv_state;
                        pc_d    = adv_pc;
                    end
                    OP_LDA, OP_LDB: begin
                        state_d = S_ISSUE;
                        datc_d  = row;
                        sel_d   = opc[1];
                        valid_d = 1'b1;
                    end
                    OP_EXEC: begin
                        state_d  = S_WAIT_EXEC;
                        xstart_d = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_ISSUE: begin
                if (bus.MAT_READY) begin
                    valid_d = 1'b0;
                    state_d = adv_state;
                    pc_d    = adv_pc;
                end
            end
            // EXEC_DONE is sampled on the EXEC_START cycle too.
            S_WAIT_EXEC: begin
                if (bus.EXEC_DONE) begin
                    state_d = adv_state;
                    pc_d    = adv_pc;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a START seen in IDLE.
        if (bus.ABORT) begin
            state_d  = S_IDLE;
            pc_d     = pc_q;
            datc_d   = datc_q;
            sel_d    = sel_q;
            valid_d  = 1'b0;
            xstart_d = 1'b0;
            done_d   = 1'b0;
            err_d    = err_q;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            datc_q   <= '0;
            sel_q    <= 1'b0;
            valid_q  <= 1'b0;
            xstart_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            datc_q   <= datc_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            xstart_q <= xstart_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.SEQ_INS    = pc_q;
    assign bus.SEQ_DATC   = datc_q;
    assign bus.MAT_SEL    = sel_q;
    assign bus.MAT_VALID  = valid_q;
    assign bus.EXEC_START = xstart_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;

endmodule
